bus_arbiter_8x1: RTL and testbench



---
 rtl/bus_arbiter_8x1.sv | 173 +++++++++++++++++
 tb/tb_bus_arbiter_8x1.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_8x1.sv
// bus_arbiter_8x1: round-robin arbiter for the eight-way 32-bit bus mux.
// One requester at a time owns the mux; the grant ends on done, on request
// withdrawal, or (with ARB_TIMEOUT_EN defined) after MAX_HOLD cycles.
// Every release is followed by one IDLE cycle before the next arbitration.
//
// Handshake: req[k] is a level request; the grant is held while req[k] stays
// high and done is low. done=1 in any GRANT cycle means the consumer took the
// word presented on r during that cycle. Both are sampled on rising edges only.
//
// Optional feature macro: ARB_TIMEOUT_EN (hold-timeout counter and the
// timeout pulse). Without it, grants are unbounded and timeout is tied low.
// busy mirrors the FSM state (high exactly in GRANT).
module bus_arbiter_8x1 #(
    parameter int MAX_HOLD = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  req,
    input  logic        done,
    input  logic [31:0] i0,
    input  logic [31:0] i1,
    input  logic [31:0] i2,
    input  logic [31:0] i3,
    input  logic [31:0] i4,
    input  logic [31:0] i5,
    input  logic [31:0] i6,
    input  logic [31:0] i7,
    output logic [31:0] r,
    output logic        s2,
    output logic        s1,
    output logic        s0,
    output logic [7:0]  gnt,
    output logic        busy,
    output logic        timeout
);

    typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("MAX_HOLD must be in 1..255");
    end

    state_t      r_state;
    logic [2:0]  r_sel;
    logic [2:0]  r_ptr;
    logic [7:0]  r_gnt;
    logic        r_tout;

    state_t      w_state_nxt;
    logic [2:0]  w_sel_nxt;
    logic [2:0]  w_ptr_nxt;
    logic [7:0]  w_gnt_nxt;
    logic        w_tout_nxt;
    logic [2:0]  w_win;
    logic [2:0]  w_idx;
    logic        w_force;
    logic        w_release;

`ifdef ARB_TIMEOUT_EN
    logic [7:0]  r_hcnt;
    logic [7:0]  w_hcnt_nxt;

    // Forced release: hold limit reached while the grant would otherwise continue.
    always_comb begin
        w_force = (r_state == ST_GRANT) && (r_hcnt == 8'(MAX_HOLD - 1)) &&
                  !done && req[r_sel];
    end
`else
    // No hold limit: grants only end normally.
    always_comb begin
        w_force = 1'b0;
    end
`endif

    // Normal or forced end of the current grant.
    always_comb begin
        w_release = done || !req[r_sel] || w_force;
    end

    // Round-robin pick: scan from ptr+7 down to ptr so the nearest requester wins.
    always_comb begin
        w_win = r_ptr;
        w_idx = r_ptr;
        for (int k = 7; k >= 0; k--) begin
            w_idx = r_ptr + 3'(k);
            if (req[w_idx]) begin
                w_win = w_idx;
            end
        end
    end

    // State register: FSM state plus all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_sel   <= 3'd0;
            r_ptr   <= 3'd0;
            r_gnt   <= 8'd0;
            r_tout  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            r_hcnt  <= 8'd0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gnt   <= w_gnt_nxt;
            r_tout  <= w_tout_nxt;
`ifdef ARB_TIMEOUT_EN
            r_hcnt  <= w_hcnt_nxt;
`endif
        end
    end

    // Next-state logic: arbitrate in IDLE, watch for release in GRANT.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        w_gnt_nxt   = r_gnt;
        w_tout_nxt  = 1'b0;
`ifdef ARB_TIMEOUT_EN
        w_hcnt_nxt  = r_hcnt;
`endif
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_state_nxt = ST_GRANT;
                    w_sel_nxt   = w_win;
                    w_gnt_nxt   = 8'd1 << w_win;
`ifdef ARB_TIMEOUT_EN
                    w_hcnt_nxt  = 8'd0;
`endif
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = 8'd0;
                    w_ptr_nxt   = r_sel + 3'd1;
                    w_tout_nxt  = w_force;
                end
`ifdef ARB_TIMEOUT_EN
                else begin
                    w_hcnt_nxt = r_hcnt + 8'd1;
                end
`endif
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs: select lines and mux follow the registered select.
    always_comb begin
        busy         = (r_state == ST_GRANT);
        gnt          = r_gnt;
        timeout      = r_tout;
        {s2, s1, s0} = r_sel;
        case (r_sel)
            3'd0:    r = i0;
            3'd1:    r = i1;
            3'd2:    r = i2;
            3'd3:    r = i3;
            3'd4:    r = i4;
            3'd5:    r = i5;
            3'd6:    r = i6;
            default: r = i7;
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter_8x1.sv
// Testbench for bus_arbiter_8x1: directed scenarios followed by random
// traffic, checked cycle by cycle against a transaction-level owner model.
module tb_bus_arbiter_8x1;

    localparam int MAXH = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0]  gnt;
        logic        busy;
        logic [2:0]  sel;
        logic [31:0] r;
        logic        tout;
    } exp_t;

    // ---------------- clock / reset / DUT ----------------
    logic        clk;
    logic        reset;
    logic [7:0]  req;
    logic        done;
    logic [31:0] din [8];
    logic [31:0] r;
    logic        s2, s1, s0;
    logic [7:0]  gnt;
    logic        busy;
    logic        timeout;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bus_arbiter_8x1 #(.MAX_HOLD(MAXH)) dut (
        .clk(clk), .reset(reset), .req(req), .done(done),
        .i0(din[0]), .i1(din[1]), .i2(din[2]), .i3(din[3]),
        .i4(din[4]), .i5(din[5]), .i6(din[6]), .i7(din[7]),
        .r(r), .s2(s2), .s1(s1), .s0(s0),
        .gnt(gnt), .busy(busy), .timeout(timeout)
    );

    // ---------------- reference model ----------------
    // owner = requester holding the bus (-1 none); held = grant cycles so far.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    int m_sel   = 0;
    bit m_tout  = 1'b0;

    logic [$bits(exp_t)-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic model_edge(input logic [7:0] rq, input logic dn, input logic rs);
        bit forced;
        if (rs) begin
            m_owner = -1; m_ptr = 0; m_held = 0; m_sel = 0; m_tout = 1'b0;
        end else if (m_owner < 0) begin
            m_tout = 1'b0;
            for (int k = 0; k < 8; k++) begin
                if (rq[(m_ptr + k) % 8]) begin
                    m_owner = (m_ptr + k) % 8;
                    break;
                end
            end
            if (m_owner >= 0) begin
                m_held = 1;
                m_sel  = m_owner;
            end
        end else begin
            forced = TO_EN && (m_held == MAXH) && !dn && rq[m_owner];
            if (dn || !rq[m_owner] || forced) begin
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
                m_tout  = forced;
            end else begin
                m_held++;
                m_tout = 1'b0;
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic [7:0] rq, input logic dn, input logic rs);
        exp_t e;
        req   = rq;
        done  = dn;
        reset = rs;
        model_edge(rq, dn, rs);
        e.gnt  = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
        e.busy = (m_owner >= 0);
        e.sel  = 3'(m_sel);
        e.r    = din[m_sel];
        e.tout = m_tout;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, act, expv);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_t'(exp_q.pop_front());
                chk("gnt",     32'(gnt),          32'(e.gnt));
                chk("busy",    32'(busy),         32'(e.busy));
                chk("select",  32'({s2, s1, s0}), 32'(e.sel));
                chk("r",       r,                 e.r);
                chk("timeout", 32'(timeout),      32'(e.tout));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] rq;
        for (int k = 0; k < 8; k++) din[k] = 32'(k);
        req = 8'd0; done = 1'b0; reset = 1'b1;

        // reset, then idle with no requests
        step(8'h00, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b1);
        repeat (5) step(8'h00, 1'b0, 1'b0);

        // single grant to 2 with done in the first grant cycle, then wrap 0 -> 1
        step(8'h04, 1'b0, 1'b0);
        step(8'h04, 1'b1, 1'b0);
        step(8'h03, 1'b0, 1'b0);
        step(8'h03, 1'b1, 1'b0);
        step(8'h03, 1'b0, 1'b0);
        step(8'h03, 1'b1, 1'b0);
        step(8'h00, 1'b0, 1'b0);

        // all requesting, done whenever busy: full rotation and wrap
        step(8'h00, 1'b0, 1'b1);
        repeat (20) step(8'hFF, 1'b1, 1'b0);

        // grant to 6, withdrawal, then reset mid-grant
        step(8'h00, 1'b0, 1'b1);
        repeat (3) step(8'h40, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        step(8'h40, 1'b0, 1'b0);
        step(8'h40, 1'b0, 1'b0);
        step(8'h40, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b0);

        // long hold on requester 5 (times out when the limit is built in)
        step(8'h00, 1'b0, 1'b1);
        repeat (12) step(8'h20, 1'b0, 1'b0);
        // done exactly on the limit cycle: no timeout pulse
        step(8'h00, 1'b0, 1'b1);
        repeat (4) step(8'h20, 1'b0, 1'b0);
        step(8'h20, 1'b1, 1'b0);
        repeat (2) step(8'h00, 1'b0, 1'b0);

        // random traffic with random data words
        rq = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < 8; k++) din[k] = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                rq = 8'($urandom);
                if ($urandom_range(0, 1) == 0) rq = rq & 8'($urandom);
            end
            step(rq, ($urandom_range(0, 4) == 0), ($urandom_range(0, 199) == 0));
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
